// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-MODULUS up/down counter with parallel load, terminal-count and wrap outputs.
// Define COUNTER_SATURATE_EN to build a saturating variant (holds at the ends, wrap tied low).
module sync_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             at_max;
  logic             at_zero;
  logic             at_end;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);
  assign at_end  = up_dn ? at_max : at_zero;

  // tc flags the step about to cross the end of the range; a pending load suppresses it
  assign tc = en & ~load & at_end;

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (!at_end) begin
        count_next = up_dn ? (count + ONE) : (count - ONE);
      end
`else
      if (at_end) begin
        count_next = up_dn ? '0 : MAX_VAL;
        wrap_next  = 1'b1;
      end else begin
        count_next = up_dn ? (count + ONE) : (count - ONE);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: two counter instances (modulus 16 and 10) driven by shared inputs,
// compared every cycle against an arithmetic reference model plus directed literal pins.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count16, count10;
  logic       tc16, tc10, wrap16, wrap10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count16), .tc(tc16), .wrap(wrap16)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count10), .tc(tc10), .wrap(wrap10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is the modulus-16 instance, index 1 the modulus-10 instance
  int m_cnt[2];
  int m_wrap[2];
  int mods[2] = '{16, 10};
  bit valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int c, w, m;
      bit boundary;
      m = mods[k];
      c = m_cnt[k];
      w = 0;
      if (reset) begin
        c = 0;
      end else if (load) begin
        c = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
      end else if (en) begin
        boundary = up_dn ? (c == m - 1) : (c == 0);
`ifdef COUNTER_SATURATE_EN
        if (!boundary) c = up_dn ? c + 1 : c - 1;
`else
        c = up_dn ? (c + 1) % m : (c + m - 1) % m;
        w = boundary ? 1 : 0;
`endif
      end
      m_cnt[k]  <= c;
      m_wrap[k] <= w;
    end
    if (reset) valid <= 1'b1;
  end

  function automatic int model_tc(input int k);
    if (!en || load) return 0;
    return (up_dn ? (m_cnt[k] == mods[k] - 1) : (m_cnt[k] == 0)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      chk("count16", 32'(count16), 32'(m_cnt[0]));
      chk("wrap16",  32'(wrap16),  32'(m_wrap[0]));
      chk("tc16",    32'(tc16),    32'(model_tc(0)));
      chk("count10", 32'(count10), 32'(m_cnt[1]));
      chk("wrap10",  32'(wrap10),  32'(m_wrap[1]));
      chk("tc10",    32'(tc10),    32'(model_tc(1)));
    end
  end

  task automatic set_in(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] v);
    reset = r; load = l; en = e; up_dn = u; load_val = v;
  endtask

  task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                     input logic [3:0] v);
    set_in(r, l, e, u, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_count16", 32'(count16), 32'd0);
    chk("reset_wrap16",  32'(wrap16),  32'd0);

    // Count up 0..15 on the modulus-16 instance
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 1, 0);
    chk("up15_count16", 32'(count16), 32'd15);
    chk("up15_wrap16",  32'(wrap16),  32'd0);
    chk("up15_tc16",    32'(tc16),    32'd1);
    cyc(0, 0, 1, 1, 0);
`ifdef COUNTER_SATURATE_EN
    chk("up16_count16", 32'(count16), 32'd15);
    chk("up16_wrap16",  32'(wrap16),  32'd0);
`else
    chk("up16_count16", 32'(count16), 32'd0);
    chk("up16_wrap16",  32'(wrap16),  32'd1);
`endif
    cyc(0, 0, 0, 1, 0);
    chk("hold_wrap16", 32'(wrap16), 32'd0);

    // Count down from reset on the modulus-10 instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
`ifdef COUNTER_SATURATE_EN
    chk("dn1_count10", 32'(count10), 32'd0);
    chk("dn1_wrap10",  32'(wrap10),  32'd0);
`else
    chk("dn1_count10", 32'(count10), 32'd9);
    chk("dn1_wrap10",  32'(wrap10),  32'd1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0);
    chk("dn10_count10", 32'(count10), 32'd0);
`endif
    set_in(0, 0, 1, 0, 0);
    #1;
    chk("dn_tc10", 32'(tc10), 32'd1);

    // Clamped load, then step up past the top
    cyc(0, 1, 1, 1, 4'd12);
    chk("clamp_count10", 32'(count10), 32'd9);
    chk("clamp_wrap10",  32'(wrap10),  32'd0);
    chk("clamp_count16", 32'(count16), 32'd12);
    cyc(0, 0, 1, 1, 0);
`ifdef COUNTER_SATURATE_EN
    chk("postclamp_count10", 32'(count10), 32'd9);
`else
    chk("postclamp_count10", 32'(count10), 32'd0);
    chk("postclamp_wrap10",  32'(wrap10),  32'd1);
`endif

    // Priority: reset beats load beats enable; load masks tc
    cyc(0, 1, 0, 0, 4'd5);
    chk("ld5_count16", 32'(count16), 32'd5);
    cyc(1, 1, 1, 1, 4'd3);
    chk("prio_count16", 32'(count16), 32'd0);
    set_in(0, 1, 1, 0, 4'd3);
    #1;
    chk("load_tc16", 32'(tc16), 32'd0);
    chk("load_tc10", 32'(tc10), 32'd0);
    cyc(0, 1, 1, 0, 4'd3);
    chk("ld3_count16", 32'(count16), 32'd3);

    // Direction flip and hold
    cyc(0, 1, 0, 0, 4'd7);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("flip_up_count16", 32'(count16), 32'd9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    chk("flip_dn_count16", 32'(count16), 32'd6);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk("hold_count16", 32'(count16), 32'd6);
    chk("hold_wrap16b", 32'(wrap16),  32'd0);

    // End-of-range behaviour from 15 upward and 0 downward
    cyc(0, 1, 0, 0, 4'd15);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
`ifdef COUNTER_SATURATE_EN
    chk("sat_up_count16", 32'(count16), 32'd15);
    chk("sat_up_wrap16",  32'(wrap16),  32'd0);
    set_in(0, 0, 1, 1, 0);
    #1;
    chk("sat_up_tc16", 32'(tc16), 32'd1);
`else
    chk("mod_up_count16", 32'(count16), 32'd2);
`endif
    cyc(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0);
`ifdef COUNTER_SATURATE_EN
    chk("sat_dn_count16", 32'(count16), 32'd0);
`else
    chk("mod_dn_count16", 32'(count16), 32'd14);
    chk("mod_dn_count10", 32'(count10), 32'd8);
`endif

    // Randomized traffic checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      logic r, l, e, u;
      logic [3:0] v;
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 10);
      e = ($urandom_range(0, 99) < 80);
      u = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 75 : 25));
      v = 4'($urandom_range(0, 15));
      cyc(r, l, e, u, v);
    end

    cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
